// File: rtl/sseg_pkg.sv
// Shared FSM states and seven-segment glyphs (bit order a..g, active-high)
// for the scanned display driver.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [0:6] GLYPH_0     = 7'b1111110;
  localparam logic [0:6] GLYPH_1     = 7'b0110000;
  localparam logic [0:6] GLYPH_2     = 7'b1101101;
  localparam logic [0:6] GLYPH_3     = 7'b1111001;
  localparam logic [0:6] GLYPH_4     = 7'b0110011;
  localparam logic [0:6] GLYPH_5     = 7'b1011011;
  localparam logic [0:6] GLYPH_6     = 7'b1011111;
  localparam logic [0:6] GLYPH_7     = 7'b1110000;
  localparam logic [0:6] GLYPH_8     = 7'b1111111;
  localparam logic [0:6] GLYPH_9     = 7'b1111011;
  localparam logic [0:6] GLYPH_A     = 7'b1110111;
  localparam logic [0:6] GLYPH_B     = 7'b0011111;
  localparam logic [0:6] GLYPH_C     = 7'b1001110;
  localparam logic [0:6] GLYPH_D     = 7'b0111101;
  localparam logic [0:6] GLYPH_E     = 7'b1001111;
  localparam logic [0:6] GLYPH_F     = 7'b1000111;
  localparam logic [0:6] GLYPH_BLANK = 7'b0000000;
  localparam logic [0:6] GLYPH_DASH  = 7'b0000001;

  function automatic logic [0:6] nib2glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    nib2glyph = GLYPH_0;
      4'h1:    nib2glyph = GLYPH_1;
      4'h2:    nib2glyph = GLYPH_2;
      4'h3:    nib2glyph = GLYPH_3;
      4'h4:    nib2glyph = GLYPH_4;
      4'h5:    nib2glyph = GLYPH_5;
      4'h6:    nib2glyph = GLYPH_6;
      4'h7:    nib2glyph = GLYPH_7;
      4'h8:    nib2glyph = GLYPH_8;
      4'h9:    nib2glyph = GLYPH_9;
      4'hA:    nib2glyph = GLYPH_A;
      4'hB:    nib2glyph = GLYPH_B;
      4'hC:    nib2glyph = GLYPH_C;
      4'hD:    nib2glyph = GLYPH_D;
      4'hE:    nib2glyph = GLYPH_E;
      default: nib2glyph = GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, W steps per
// conversion. o_done flags the cycle in which the final step is taken.
module bin2bcd_seq #(
  parameter int W    = 16,
  parameter int NBCD = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [W-1:0]      i_bin,
  output logic              o_busy,
  output logic              o_done,
  output logic [4*NBCD-1:0] o_bcd
);

  localparam int TOT   = 4*NBCD + W;
  localparam int CNT_W = $clog2(W) + 1;

  logic [TOT-1:0]   r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [TOT-1:0]   w_adj;
  logic             w_last;

  always_comb begin
    w_adj = r_sh;
    for (int unsigned i = 0; i < NBCD; i++) begin
      if (w_adj[W+4*i +: 4] >= 4'd5)
        w_adj[W+4*i +: 4] = w_adj[W+4*i +: 4] + 4'd3;
    end
  end

  assign w_last = r_busy && (r_cnt == CNT_W'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_sh   <= {{(4*NBCD){1'b0}}, i_bin};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_sh  <= {w_adj[TOT-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (w_last)
        r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_bcd  = r_sh[TOT-1:W];

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver: captures num/mode, converts to BCD or
// passes hex through, commits atomically, then scans digits with blanking.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESC_W    = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] num,
  input  logic                hex_mode,
  input  logic                blank_lz,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                en,
  output logic [0:6]          sseg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                busy
);

  localparam int W     = 4*DIGITS;
  localparam int NBCD  = DIGITS + 2;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS-1);

  state_t              r_state, w_state_nx;
  logic                r_busy;
  logic [PRESC_W-1:0]  r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [W-1:0]        r_num_cap;
  logic                r_hex_cap;
  logic [W-1:0]        r_disp;
  logic                r_ovf;
  logic [DIGITS-1:0]   r_an;
  logic [0:6]          r_sseg;
  logic                r_dp;

  logic                w_tick, w_changed, w_capture, w_start;
  logic                w_cvt_busy, w_cvt_done;
  logic [4*NBCD-1:0]   w_bcd;
  logic [3:0]          w_nib;
  logic [W-1:0]        w_upper;
  logic                w_blank;
  logic [0:6]          w_glyph;
  logic [DIGITS-1:0]   w_an_on;

  bin2bcd_seq #(.W(W), .NBCD(NBCD)) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (num),
    .o_busy  (w_cvt_busy),
    .o_done  (w_cvt_done),
    .o_bcd   (w_bcd)
  );

  assign w_changed = (num != r_num_cap) || (hex_mode != r_hex_cap);

  always_comb begin
    w_state_nx = r_state;
    w_capture  = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_changed) begin
          w_capture = 1'b1;
          if (hex_mode) begin
            w_state_nx = COMMIT;
          end else begin
            w_start    = 1'b1;
            w_state_nx = SHIFT;
          end
        end
      end
      // !busy guards against a converter that was never started
      SHIFT:   if (w_cvt_done || !w_cvt_busy) w_state_nx = COMMIT;
      COMMIT:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_cap <= '0;
      r_hex_cap <= 1'b0;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_num_cap <= num;
        r_hex_cap <= hex_mode;
      end
      if (r_state == COMMIT) begin
        r_disp <= r_hex_cap ? r_num_cap : w_bcd[W-1:0];
        r_ovf  <= !r_hex_cap && (|w_bcd[4*NBCD-1:W]);
      end
    end
  end

  assign w_tick = (r_presc == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Active digit is blanked when it and every digit above it are zero.
  assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
  assign w_upper = r_disp >> {r_idx, 2'b00};
  assign w_blank = blank_lz && !r_ovf && (r_idx != '0) && (w_upper == '0);
  assign w_glyph = r_ovf   ? GLYPH_DASH  :
                   w_blank ? GLYPH_BLANK : nib2glyph(w_nib);
  assign w_an_on = en ? (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= {DIGITS{ACTIVE_LOW}};
      r_sseg <= {7{ACTIVE_LOW}};
      r_dp   <= ACTIVE_LOW;
    end else begin
      r_an   <= w_an_on ^ {DIGITS{ACTIVE_LOW}};
      r_sseg <= w_glyph ^ {7{ACTIVE_LOW}};
      r_dp   <= dp_in[r_idx] ^ ACTIVE_LOW;
    end
  end

  assign an   = r_an;
  assign sseg = r_sseg;
  assign dp   = r_dp;
  assign busy = r_busy;

endmodule
